// File: rtl/rf_exec_sequencer.sv
// Single-issue execute sequencer sitting between decode and a 32x32 register file.
// One instruction runs the sequence IDLE -> READ -> CAPT -> EXEC -> WRITE.
// Shifts iterate one bit per EXEC cycle; every other op finishes EXEC in one cycle.
module rf_exec_sequencer #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           op,
    input  logic [NREG_BITS-1:0] rs1_in,
    input  logic [NREG_BITS-1:0] rs2_in,
    input  logic [NREG_BITS-1:0] rd_in,
    input  logic [XLEN-1:0]      imm,
    input  logic                 use_imm,
    output logic [NREG_BITS-1:0] rf_rs1,
    output logic [NREG_BITS-1:0] rf_rs2,
    output logic [NREG_BITS-1:0] rf_rd,
    output logic                 rf_readEn,
    output logic                 rf_writeEn,
    output logic [XLEN-1:0]      rf_dataIn,
    input  logic [XLEN-1:0]      rf_readOut1,
    input  logic [XLEN-1:0]      rf_readOut2,
    output logic [XLEN-1:0]      result,
    output logic                 result_valid,
    output logic                 illegal_op,
    output logic                 busy
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t state, next_state;

    // Latched instruction fields and operands
    logic [3:0]      op_q;
    logic [XLEN-1:0] imm_q;
    logic            use_imm_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [SHW-1:0]  cnt_q;

    // Combinational datapath
    logic [XLEN-1:0] b_next;
    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] shift1;
    logic [XLEN-1:0] exec_val;
    logic            is_shift;
    logic            exec_done;
    logic            op_illegal;

    assign op_illegal = (op_q > 4'd10);
    assign b_next     = use_imm_q ? imm_q : rf_readOut2;

    // ALU for single-cycle ops and the one-bit shift step used by the iterative shifter
    always_comb begin
        alu_val  = '0;
        shift1   = a_q;
        is_shift = 1'b0;
        case (op_q)
            4'd0:  alu_val = a_q + b_q;
            4'd1:  alu_val = a_q - b_q;
            4'd2:  alu_val = a_q & b_q;
            4'd3:  alu_val = a_q | b_q;
            4'd4:  alu_val = a_q ^ b_q;
            4'd5:  alu_val = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            4'd6:  alu_val = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            4'd7:  begin is_shift = 1'b1; shift1 = {a_q[XLEN-2:0], 1'b0}; end
            4'd8:  begin is_shift = 1'b1; shift1 = {1'b0, a_q[XLEN-1:1]}; end
            4'd9:  begin is_shift = 1'b1; shift1 = {a_q[XLEN-1], a_q[XLEN-1:1]}; end
            4'd10: alu_val = b_q;
            default: alu_val = '0;
        endcase
    end

    // Shifts take max(1, shamt) EXEC cycles; the last cycle applies the final bit (if any)
    assign exec_done = !is_shift || (cnt_q <= SHW'(1));
    assign exec_val  = is_shift ? ((cnt_q != '0) ? shift1 : a_q) : alu_val;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else if (en)
            state <= next_state;
    end

    // Next-state and strobe decode; en low holds the FSM and silences every strobe
    always_comb begin
        next_state   = state;
        instr_ready  = 1'b0;
        rf_readEn    = 1'b0;
        rf_writeEn   = 1'b0;
        result_valid = 1'b0;
        illegal_op   = 1'b0;
        busy         = (state != IDLE);
        if (en) begin
            case (state)
                IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid)
                        next_state = READ;
                end
                READ: begin
                    rf_readEn  = 1'b1;
                    next_state = CAPT;
                end
                CAPT: next_state = EXEC;
                EXEC: begin
                    if (exec_done)
                        next_state = WRITE;
                end
                WRITE: begin
                    result_valid = 1'b1;
                    illegal_op   = op_illegal;
                    // x0 is hardwired to zero, so rd==0 reports the result without writing
                    rf_writeEn   = !op_illegal && (rf_rd != '0);
                    next_state   = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Instruction latch, operand capture, shift iteration and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            rf_rs1    <= '0;
            rf_rs2    <= '0;
            rf_rd     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            result    <= '0;
            rf_dataIn <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q      <= op;
                        imm_q     <= imm;
                        use_imm_q <= use_imm;
                        rf_rs1    <= rs1_in;
                        rf_rs2    <= rs2_in;
                        rf_rd     <= rd_in;
                    end
                end
                CAPT: begin
                    a_q   <= rf_readOut1;
                    b_q   <= b_next;
                    cnt_q <= b_next[SHW-1:0];
                end
                EXEC: begin
                    if (!exec_done) begin
                        a_q   <= shift1;
                        cnt_q <= cnt_q - SHW'(1);
                    end else begin
                        result    <= exec_val;
                        rf_dataIn <= exec_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Directed bench for rf_exec_sequencer with a registered-read register-file model
// and a scoreboard of expected write-back results.
module tb_rf_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  op;
    logic [4:0]  rs1_in, rs2_in, rd_in;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic        rf_readEn, rf_writeEn;
    logic [31:0] rf_dataIn;
    logic [31:0] rf_readOut1 = 32'h0;
    logic [31:0] rf_readOut2 = 32'h0;
    logic [31:0] result;
    logic        result_valid, illegal_op, busy;

    always #5 clk = ~clk;

    rf_exec_sequencer #(.XLEN(32), .NREG_BITS(5)) dut (
        .clk(clk), .reset(reset), .en(en),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .imm(imm), .use_imm(use_imm),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
        .rf_readEn(rf_readEn), .rf_writeEn(rf_writeEn), .rf_dataIn(rf_dataIn),
        .rf_readOut1(rf_readOut1), .rf_readOut2(rf_readOut2),
        .result(result), .result_valid(result_valid),
        .illegal_op(illegal_op), .busy(busy)
    );

    // Register file: registered reads, readEn has priority over writeEn, x0 reads as 0
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (en) begin
            if (rf_readEn) begin
                rf_readOut1 <= (rf_rs1 == 5'd0) ? 32'h0 : mem[rf_rs1];
                rf_readOut2 <= (rf_rs2 == 5'd0) ? 32'h0 : mem[rf_rs2];
            end else if (rf_writeEn && rf_rd != 5'd0) begin
                mem[rf_rd] <= rf_dataIn;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] gold [0:31];
    logic [31:0] exp_q[$];
    logic        exp_wr_q[$];
    logic        exp_ill_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return $unsigned($signed(a) >>> b[4:0]);
            4'd10: return b;
            default: return 32'h0;
        endcase
    endfunction

    // Issue one instruction and follow it to completion; drop_at>0 lowers en for
    // three cycles starting at that cycle after the accept edge.
    task automatic run(input logic [3:0] o, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [31:0] im, input logic ui,
                       input int drop_at);
        logic [31:0] a, b, e, got_e;
        logic        wr, got_wr, got_ill;
        int          lat, n;
        bit          seen;
        a  = (s1 == 5'd0) ? 32'h0 : gold[s1];
        b  = ui ? im : ((s2 == 5'd0) ? 32'h0 : gold[s2]);
        e  = model(o, a, b);
        wr = (o <= 4'd10) && (d != 5'd0);
        exp_q.push_back(e);
        exp_wr_q.push_back(wr);
        exp_ill_q.push_back(o > 4'd10);
        lat = 3 + ((o >= 4'd7 && o <= 4'd9 && b[4:0] > 5'd1) ? int'(b[4:0]) : 1) + ((drop_at != 0) ? 3 : 0);

        @(negedge clk);
        instr_valid = 1'b1; op = o; rs1_in = s1; rs2_in = s2; rd_in = d; imm = im; use_imm = ui;
        #1 chk("instr_ready_idle", {31'b0, instr_ready}, 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;

        n = 0; seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (drop_at != 0 && n == drop_at)     en = 1'b0;
            if (drop_at != 0 && n == drop_at + 3) en = 1'b1;
            #1;
            if (n == 1) chk("readEn_cycle1", {31'b0, rf_readEn}, 32'd1);
            else        chk("readEn_off", {31'b0, rf_readEn}, 32'd0);
            if (!en) begin
                chk("frozen_strobes", {28'b0, rf_writeEn, result_valid, illegal_op, instr_ready}, 32'd0);
                chk("frozen_busy", {31'b0, busy}, 32'd1);
            end
            if (result_valid) seen = 1;
            else chk("writeEn_early", {31'b0, rf_writeEn}, 32'd0);
        end
        chk("latency", 32'(n), 32'(lat));
        got_e   = exp_q.pop_front();
        got_wr  = exp_wr_q.pop_front();
        got_ill = exp_ill_q.pop_front();
        chk("result", result, got_e);
        chk("rf_dataIn", rf_dataIn, got_e);
        chk("rf_writeEn", {31'b0, rf_writeEn}, {31'b0, got_wr});
        chk("illegal_op", {31'b0, illegal_op}, {31'b0, got_ill});
        if (got_wr) chk("rf_rd", {27'b0, rf_rd}, {27'b0, d});
        if (got_wr) gold[d] = got_e;

        @(negedge clk);
        #1;
        chk("pulse_end", {30'b0, result_valid, rf_writeEn}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_ready", {31'b0, instr_ready}, 32'd1);
        if (got_wr) chk("regfile_write", mem[d], got_e);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) gold[i] = 32'h0;
        reset = 1'b0; en = 1'b1; instr_valid = 1'b0;
        op = 4'd0; rs1_in = 5'd0; rs2_in = 5'd0; rd_in = 5'd0; imm = 32'h0; use_imm = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_strobes", {28'b0, rf_readEn, rf_writeEn, result_valid, illegal_op}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_dataIn", rf_dataIn, 32'h0);
        chk("rst_addr", {17'b0, rf_rs1, rf_rs2, rf_rd}, 32'h0);
        reset = 1'b1;

        run(4'd10, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 0);            // PASSB x1=5
        run(4'd10, 5'd0, 5'd0, 5'd1, 32'd7, 1'b1, 0);            // x1=7
        run(4'd10, 5'd0, 5'd0, 5'd2, 32'hFFFF_FFFF, 1'b1, 0);    // x2=-1
        run(4'd0,  5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 0);            // ADD -> 6
        run(4'd5,  5'd2, 5'd1, 5'd4, 32'h0, 1'b0, 0);            // SLT -> 1
        run(4'd6,  5'd2, 5'd1, 5'd4, 32'h0, 1'b0, 0);            // SLTU -> 0
        run(4'd1,  5'd1, 5'd2, 5'd9, 32'h0, 1'b0, 0);            // SUB -> 8
        run(4'd2,  5'd2, 5'd1, 5'd10, 32'h0, 1'b0, 0);           // AND
        run(4'd3,  5'd3, 5'd9, 5'd10, 32'h0, 1'b0, 0);           // OR
        run(4'd4,  5'd1, 5'd2, 5'd11, 32'h0, 1'b0, 0);           // XOR
        run(4'd0,  5'd1, 5'd2, 5'd11, 32'h0, 1'b0, 2);           // ADD with en low in CAPT
        run(4'd10, 5'd0, 5'd0, 5'd1, 32'h8000_0000, 1'b1, 0);    // x1=0x80000000
        run(4'd9,  5'd1, 5'd0, 5'd5, 32'd4, 1'b1, 0);            // SRA 4 -> F8000000
        run(4'd7,  5'd1, 5'd0, 5'd6, 32'd0, 1'b1, 0);            // SLL 0 -> unchanged
        run(4'd8,  5'd1, 5'd0, 5'd12, 32'd4, 1'b1, 0);           // SRL 4
        run(4'd7,  5'd3, 5'd9, 5'd13, 32'h0, 1'b0, 0);           // SLL by register (8)
        run(4'd0,  5'd1, 5'd0, 5'd0, 32'd3, 1'b1, 0);            // ADD rd=0: no write
        run(4'd12, 5'd1, 5'd2, 5'd14, 32'h0, 1'b0, 0);           // illegal op
        run(4'd10, 5'd0, 5'd0, 5'd7, 32'h0000_1234, 1'b1, 0);    // x7=0x1234

        // Asynchronous reset in the middle of a 4-cycle SRA targeting x7
        @(negedge clk);
        instr_valid = 1'b1; op = 4'd9; rs1_in = 5'd1; rs2_in = 5'd0; rd_in = 5'd7;
        imm = 32'd4; use_imm = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_strobes", {29'b0, rf_readEn, rf_writeEn, result_valid}, 32'd0);
        chk("arst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("arst_ready", {31'b0, instr_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 chk("arst_no_write", {30'b0, rf_writeEn, result_valid}, 32'd0);
        end
        chk("arst_x7_kept", mem[7], 32'h0000_1234);

        run(4'd8, 5'd2, 5'd0, 5'd8, 32'd3, 1'b1, 0);             // SRL after recovery
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
